// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: core-clock register bank behind an SPI slave.
// Brings the SPI write strobe into the core domain, commits writes to the
// ID/STATUS/IRQ/WR_COUNT/CFG register map, returns registered read data and
// drives cfg_out, wr_strobe/wr_addr and the irq line.
// Optional build macro SPI_REG_SHADOW_EN: CFG writes land in shadow registers
// and reach cfg_out only when 0x05 is written with bit 0 set.
module spi_reg_bridge #(
    parameter int          NUM_CFG     = 8,
    parameter logic [31:0] ID_VALUE    = 32'h5350_4901,
    parameter logic [31:0] CFG_RST_VAL = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             spi_addr,
    input  logic [31:0]            spi_wdata,
    input  logic                   spi_wr_valid,
    output logic [31:0]            spi_rdata,
    input  logic [31:0]            sts_in,
    input  logic [30:0]            irq_set,
    output logic [32*NUM_CFG-1:0]  cfg_out,
    output logic                   wr_strobe,
    output logic [6:0]             wr_addr,
    output logic                   irq
);

    localparam int CFG_BASE = 16;

    logic        wr_s1, wr_s2, wr_s3;
    logic        wr_det;
    logic [6:0]  rd_a1, rd_a2;
    logic [6:0]  wa;
    logic        unused_addr_msb;
    logic [31:0] cfg_q [NUM_CFG];
    logic [31:0] irq_status, irq_enable, wr_count;
    logic [31:0] w1c_mask;
    logic        wr_ien, wr_unmapped, wr_cfg_hit;
    logic [31:0] rd_val;
`ifdef SPI_REG_SHADOW_EN
    logic [31:0] sh_q [NUM_CFG];
    logic        wr_commit;
`endif

    assign wa              = spi_addr[6:0];
    assign unused_addr_msb = spi_addr[7];
    // The write address/data are held upstream until chip-select drops, so
    // they are sampled directly when the synchronized strobe rises.
    assign wr_det          = wr_s2 & ~wr_s3;

    // Synchronize the write strobe and the read address into the core domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_s1 <= 1'b0;
            wr_s2 <= 1'b0;
            wr_s3 <= 1'b0;
            rd_a1 <= '0;
            rd_a2 <= '0;
        end else begin
            wr_s1 <= spi_wr_valid;
            wr_s2 <= wr_s1;
            wr_s3 <= wr_s2;
            rd_a1 <= wa;
            rd_a2 <= rd_a1;
        end
    end

    // Decode the committing write into per-register actions.
    always_comb begin
        w1c_mask    = '0;
        wr_ien      = 1'b0;
        wr_unmapped = 1'b0;
        wr_cfg_hit  = 1'b0;
`ifdef SPI_REG_SHADOW_EN
        wr_commit   = 1'b0;
`endif
        for (int i = 0; i < NUM_CFG; i++)
            if (wa == 7'(CFG_BASE + i)) wr_cfg_hit = 1'b1;
        if (wr_det) begin
            case (wa)
                7'h00, 7'h01, 7'h04: ;
                7'h02: w1c_mask = spi_wdata;
                7'h03: wr_ien = 1'b1;
                7'h05: begin
`ifdef SPI_REG_SHADOW_EN
                    wr_commit = spi_wdata[0];
`endif
                end
                default: wr_unmapped = ~wr_cfg_hit;
            endcase
        end
    end

    // Control registers: IRQ status/enable, write counter, strobe and irq.
    // A set pulse wins over a W1C clear of the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_status <= '0;
            irq_enable <= '0;
            wr_count   <= '0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            irq        <= 1'b0;
        end else begin
            irq_status <= (irq_status & ~w1c_mask) | {wr_unmapped, irq_set};
            if (wr_ien) irq_enable <= spi_wdata;
            if (wr_det) begin
                wr_count <= wr_count + 32'd1;
                wr_addr  <= wa;
            end
            wr_strobe <= wr_det;
            irq       <= |(irq_status & irq_enable);
        end
    end

    // CFG storage: direct writes, or shadow writes plus a bulk commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                cfg_q[i] <= CFG_RST_VAL;
`ifdef SPI_REG_SHADOW_EN
                sh_q[i]  <= CFG_RST_VAL;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
`ifdef SPI_REG_SHADOW_EN
                if (wr_det && wa == 7'(CFG_BASE + i)) sh_q[i] <= spi_wdata;
                if (wr_commit) cfg_q[i] <= sh_q[i];
`else
                if (wr_det && wa == 7'(CFG_BASE + i)) cfg_q[i] <= spi_wdata;
`endif
            end
        end
    end

    // Flatten CFG registers onto cfg_out, CFG0 in the low word.
    always_comb begin
        cfg_out = '0;
        for (int i = 0; i < NUM_CFG; i++)
            cfg_out[32*i +: 32] = cfg_q[i];
    end

    // Read mux over the synchronized address; unmapped and COMMIT read as 0.
    always_comb begin
        rd_val = '0;
        case (rd_a2)
            7'h00:   rd_val = ID_VALUE;
            7'h01:   rd_val = sts_in;
            7'h02:   rd_val = irq_status;
            7'h03:   rd_val = irq_enable;
            7'h04:   rd_val = wr_count;
            default: ;
        endcase
        for (int i = 0; i < NUM_CFG; i++) begin
            if (rd_a2 == 7'(CFG_BASE + i)) begin
`ifdef SPI_REG_SHADOW_EN
                rd_val = sh_q[i];
`else
                rd_val = cfg_q[i];
`endif
            end
        end
    end

    // Registered read data; reset value matches the reset address (ID).
    always_ff @(posedge clk) begin
        if (rst) spi_rdata <= ID_VALUE;
        else     spi_rdata <= rd_val;
    end

endmodule
